// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// read-FSM states and default timing constants used by sdram_init,
// sdram_write and sdram_read.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  localparam int TRCD_CLK_DEF = 2;
  localparam int CL_CLK_DEF   = 3;
  localparam int TRP_CLK_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT,
    ST_TRCD,
    ST_RD,
    ST_RD_DATA,
    ST_PRE,
    ST_TRP,
    ST_END
  } rd_state_e;

  // Column address for READ/WRITE: A10 stays low so no auto-precharge happens.
  function automatic logic [12:0] col_to_addr(input logic [8:0] col);
    return {4'b0000, col};
  endfunction

endpackage

// File: rtl/sdram_read.sv
// sdram_read: single-row full-page burst read engine.
// ACTIVE -> tRCD -> READ -> BURST_STOP after burst_len words -> PRECHARGE all
// -> tRP -> rd_end pulse. One cycle counter, reloaded per state, times tRCD,
// the data phase and tRP. Define SDRAM_READ_OUT_REG_EN to register the read
// data (rd_ack window then shifts one cycle later).
module sdram_read
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = TRCD_CLK_DEF,
  parameter int CL_CLK   = CL_CLK_DEF,
  parameter int TRP_CLK  = TRP_CLK_DEF
) (
  input  logic        clk_100m,
  input  logic        rstn,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] sdram_data_in,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [15:0] rd_sdram_data,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr
);

  // Wide enough to count up to CL_CLK + 1023 without wrapping.
  localparam int CNT_W = $clog2(CL_CLK + 1024);
  localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(TRCD_CLK - 1);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP_CLK - 1);
  localparam logic [CNT_W-1:0] CL_CNT    = CNT_W'(CL_CLK);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] len_q, rd_last;
  logic [1:0]       bank_lat_q;
  logic [8:0]       col_lat_q;
  logic [3:0]       cmd_q, cmd_d;
  logic [1:0]       bank_q, bank_d;
  logic [12:0]      addr_q, addr_d;
  logic             end_q, end_d;
  logic             start;
  logic             ack_win;

  assign start   = (state_q == ST_IDLE) && init_end && rd_en;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // Counter value of the last data-phase cycle (t0 + CL + len), cnt = 0 at READ.
  assign rd_last = CL_CNT + len_q;

  // Capture bank, column and effective burst length (0 means 1) at transaction start.
  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      bank_lat_q <= '0;
      col_lat_q  <= '0;
      len_q      <= '0;
    end else if (start) begin
      bank_lat_q <= rd_addr[23:22];
      col_lat_q  <= rd_addr[8:0];
      len_q      <= (rd_burst_len == '0) ? CNT_W'(1) : CNT_W'(rd_burst_len);
    end
  end

  // State, counter and registered command/bank/address outputs.
  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      bank_q  <= '0;
      addr_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
    end
  end

  // Next state and the command to present during the next state's first cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    bank_d  = bank_q;
    addr_d  = '0;
    end_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACT;
          cmd_d   = CMD_ACTIVE;
          bank_d  = rd_addr[23:22];
          addr_d  = rd_addr[21:9];
        end
      end
      ST_ACT: begin
        state_d = ST_TRCD;
        cnt_d   = '0;
      end
      ST_TRCD: begin
        if (cnt_q == TRCD_LAST) begin
          state_d = ST_RD;
          cnt_d   = '0;
          cmd_d   = CMD_READ;
          bank_d  = bank_lat_q;
          addr_d  = col_to_addr(col_lat_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RD: begin
        state_d = ST_RD_DATA;
        cnt_d   = cnt_inc;
        if (cnt_inc == len_q) cmd_d = CMD_BURST_STOP;
      end
      ST_RD_DATA: begin
        if (cnt_q == rd_last) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          cmd_d   = CMD_PRECHARGE;
          addr_d  = 13'h0400;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) cmd_d = CMD_BURST_STOP;
        end
      end
      ST_PRE: begin
        state_d = ST_TRP;
        cnt_d   = '0;
      end
      ST_TRP: begin
        if (cnt_q == TRP_LAST) begin
          state_d = ST_END;
          cnt_d   = '0;
          end_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Words arrive on DQ from t0 + CL for burst_len cycles.
  assign ack_win = ((state_q == ST_RD) || (state_q == ST_RD_DATA)) &&
                   (cnt_q >= CL_CNT) && (cnt_q < rd_last);

`ifdef SDRAM_READ_OUT_REG_EN
  logic        ack_q;
  logic [15:0] data_q;

  // Register the DQ word together with its valid flag.
  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_win;
      data_q <= sdram_data_in;
    end
  end

  assign rd_ack        = ack_q;
  assign rd_sdram_data = data_q;
`else
  assign rd_ack        = ack_win;
  assign rd_sdram_data = sdram_data_in;
`endif

  assign rd_end        = end_q;
  assign rd_sdram_cmd  = cmd_q;
  assign rd_sdram_bank = bank_q;
  assign rd_sdram_addr = addr_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: a transaction-level timeline model predicts every
// output per cycle, a small SDRAM device model drives DQ from the commands it
// sees, and directed scenarios pin the model with hand-computed values.
`timescale 1ns/1ps
module tb_sdram_read;
  import sdram_pkg::*;

  localparam int TRCD = 2;
  localparam int CL   = 3;
  localparam int TRP  = 2;
`ifdef SDRAM_READ_OUT_REG_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int MAXC = 20000;

  logic        clk_100m = 1'b0;
  logic        rstn = 1'b0;
  logic        init_end = 1'b0;
  logic        rd_en = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  rd_burst_len = '0;
  logic [15:0] sdram_data_in = '0;
  logic        rd_ack, rd_end;
  logic [15:0] rd_sdram_data;
  logic [3:0]  rd_sdram_cmd;
  logic [1:0]  rd_sdram_bank;
  logic [12:0] rd_sdram_addr;

  sdram_read #(.TRCD_CLK(TRCD), .CL_CLK(CL), .TRP_CLK(TRP)) dut (
    .clk_100m      (clk_100m),
    .rstn          (rstn),
    .init_end      (init_end),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_burst_len  (rd_burst_len),
    .sdram_data_in (sdram_data_in),
    .rd_ack        (rd_ack),
    .rd_end        (rd_end),
    .rd_sdram_data (rd_sdram_data),
    .rd_sdram_cmd  (rd_sdram_cmd),
    .rd_sdram_bank (rd_sdram_bank),
    .rd_sdram_addr (rd_sdram_addr)
  );

  always #5 clk_100m = ~clk_100m;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory contents: each word encodes where it lives.
  function automatic logic [15:0] mem_word(input logic [1:0] b, input logic [12:0] r,
                                           input logic [8:0] c);
    return {b, r[4:0], c};
  endfunction

  // ---------------- expected timeline ----------------
  logic [3:0]  e_cmd  [MAXC];
  logic [1:0]  e_bank [MAXC];
  logic [12:0] e_addr [MAXC];
  logic        e_ack  [MAXC];
  logic [15:0] e_data [MAXC];
  logic        e_end  [MAXC];
  int          next_free = 0;

  function automatic void clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_cmd[i] = CMD_NOP; e_bank[i] = '0; e_addr[i] = '0;
      e_ack[i] = 1'b0;    e_data[i] = '0; e_end[i] = 1'b0;
    end
  endfunction

  // A transaction whose ACTIVE appears in cycle a.
  function automatic void fill_txn(input int a, input logic [23:0] ad, input logic [9:0] ln);
    int l, t0, p, e;
    l  = (ln == 10'd0) ? 1 : int'(ln);
    t0 = a + TRCD + 1;
    p  = t0 + CL + l + 1;
    e  = p + TRP + 1;
    next_free = e + 1;
    if (e + 1 >= MAXC) return;
    e_cmd[a]  = CMD_ACTIVE;     e_bank[a]  = ad[23:22]; e_addr[a]  = ad[21:9];
    e_cmd[t0] = CMD_READ;       e_bank[t0] = ad[23:22]; e_addr[t0] = {4'b0000, ad[8:0]};
    e_cmd[t0 + l] = CMD_BURST_STOP;
    e_cmd[p]  = CMD_PRECHARGE;
    e_end[e]  = 1'b1;
    for (int k = 0; k < l; k++) begin
      e_ack[t0 + CL + OFS + k]  = 1'b1;
      e_data[t0 + CL + OFS + k] = mem_word(ad[23:22], ad[21:9], 9'(int'(ad[8:0]) + k));
    end
  endfunction

  // Cycle counter and transaction start rule: DUT idle and request present.
  always @(posedge clk_100m) begin
    cyc++;
    if (rstn && init_end && rd_en && (cyc - 1) >= next_free) fill_txn(cyc, rd_addr, rd_burst_len);
  end

  // Compare DUT against the timeline every cycle out of reset.
  always @(negedge clk_100m) begin
    if (rstn && cyc < MAXC) begin
      check("cmd", 32'(rd_sdram_cmd), 32'(e_cmd[cyc]));
      if (e_cmd[cyc] == CMD_ACTIVE || e_cmd[cyc] == CMD_READ) begin
        check("bank", 32'(rd_sdram_bank), 32'(e_bank[cyc]));
        check("addr", 32'(rd_sdram_addr), 32'(e_addr[cyc]));
      end
      if (e_cmd[cyc] == CMD_PRECHARGE) check("pre_a10", 32'(rd_sdram_addr[10]), 32'd1);
      check("ack", 32'(rd_ack), 32'(e_ack[cyc]));
      check("end", 32'(rd_end), 32'(e_end[cyc]));
      if (e_ack[cyc]) check("data", 32'(rd_sdram_data), 32'(e_data[cyc]));
    end
  end

  // ---------------- SDRAM device model ----------------
  logic [12:0] dev_row [4];
  logic        dev_on = 1'b0;
  int          dev_t0 = 0;
  int          dev_stop = 0;
  logic [1:0]  dev_bank = '0;
  logic [8:0]  dev_col = '0;

  always @(negedge clk_100m) begin
    if (rstn) begin
      if (rd_sdram_cmd == CMD_ACTIVE) dev_row[rd_sdram_bank] = rd_sdram_addr;
      else if (rd_sdram_cmd == CMD_READ) begin
        dev_on = 1'b1; dev_t0 = cyc; dev_stop = 2 * MAXC;
        dev_bank = rd_sdram_bank; dev_col = rd_sdram_addr[8:0];
      end else if (rd_sdram_cmd == CMD_BURST_STOP) dev_stop = cyc;
    end
  end

  always @(negedge rstn) begin
    dev_on = 1'b0;
    sdram_data_in = '0;
  end

  always @(posedge clk_100m) begin
    #1;
    if (dev_on && rstn && cyc >= dev_t0 + CL && cyc < dev_stop + CL)
      sdram_data_in = mem_word(dev_bank, dev_row[dev_bank], 9'(int'(dev_col) + cyc - dev_t0 - CL));
    else
      sdram_data_in = '0;
  end

  // ---------------- monitor ----------------
  int          m_act_cnt = 0, m_rd_cnt = 0, m_pre_cnt = 0, m_end_cnt = 0;
  int          m_nonnop = 0, m_ack_n = 0;
  int          m_act = 0, m_rd = 0, m_bst = 0, m_pre = 0, m_end = 0, m_ack_first = 0;
  logic [12:0] m_act_addr = '0, m_rd_addr = '0;
  logic [3:0]  m_first_cmd = '0;
  logic [15:0] m_data [$];

  always @(negedge clk_100m) begin
    if (rstn) begin
      if (rd_sdram_cmd != CMD_NOP) begin
        if (m_nonnop == 0) m_first_cmd = rd_sdram_cmd;
        m_nonnop++;
      end
      if (rd_sdram_cmd == CMD_ACTIVE) begin m_act_cnt++; m_act = cyc; m_act_addr = rd_sdram_addr; end
      if (rd_sdram_cmd == CMD_READ) begin m_rd_cnt++; m_rd = cyc; m_rd_addr = rd_sdram_addr; end
      if (rd_sdram_cmd == CMD_BURST_STOP) m_bst = cyc;
      if (rd_sdram_cmd == CMD_PRECHARGE) begin m_pre_cnt++; m_pre = cyc; end
      if (rd_end) begin m_end_cnt++; m_end = cyc; end
      if (rd_ack) begin
        if (m_ack_n == 0) m_ack_first = cyc;
        m_ack_n++;
        m_data.push_back(rd_sdram_data);
      end
    end
  end

  task automatic clear_mon();
    m_nonnop = 0;
    m_ack_n  = 0;
    m_data.delete();
  endtask

  function automatic int ev_cnt(input int which);
    case (which)
      0:       return m_act_cnt;
      1:       return m_rd_cnt;
      default: return m_end_cnt;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int base, input string name);
    for (int i = 0; i < 3000 && ev_cnt(which) == base; i++) @(posedge clk_100m);
    check(name, 32'(ev_cnt(which) > base), 32'd1);
  endtask

  // Request one transaction; scramble the inputs once ACTIVE is seen.
  task automatic run_txn(input logic [23:0] ad, input logic [9:0] ln, input logic hold);
    int a0, e0;
    @(posedge clk_100m); #1;
    rd_en = 1'b1; rd_addr = ad; rd_burst_len = ln;
    a0 = m_act_cnt;
    wait_ev(0, a0, "act_seen");
    #1;
    e0 = m_end_cnt;
    rd_addr = 24'($urandom);
    rd_burst_len = 10'($urandom_range(0, 15));
    rd_en = hold;
    wait_ev(2, e0, "end_seen");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd"},  32'(rd_sdram_cmd),  32'h7);
    check({tag, "_bank"}, 32'(rd_sdram_bank), 32'h0);
    check({tag, "_addr"}, 32'(rd_sdram_addr), 32'h0);
    check({tag, "_data"}, 32'(rd_sdram_data), 32'h0);
    check({tag, "_ack"},  32'(rd_ack),        32'h0);
    check({tag, "_end"},  32'(rd_end),        32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp37 [8];
    int e_before, pre0;
    exp37 = '{16'h4BFC, 16'h4BFD, 16'h4BFE, 16'h4BFF, 16'h4A00, 16'h4A01, 16'h4A02, 16'h4A03};
    clear_from(0);

    // Reset values
    repeat (3) @(posedge clk_100m);
    #1;
    check_reset_vals("rst");
    @(negedge clk_100m);
    rstn = 1'b1;

    // No init: only NOPs, no ack, no end
    @(posedge clk_100m); #1;
    clear_mon();
    e_before = m_end_cnt;
    init_end = 1'b0; rd_en = 1'b1; rd_addr = 24'($urandom); rd_burst_len = 10'd5;
    repeat (100) @(posedge clk_100m);
    #1;
    rd_en = 1'b0; init_end = 1'b1;
    check("noinit_cmds", 32'(m_nonnop), 32'd0);
    check("noinit_ack", 32'(m_ack_n), 32'd0);
    check("noinit_end", 32'(m_end_cnt - e_before), 32'd0);

    // Basic: addr 0, len 10, data 0..9
    clear_mon();
    e_before = m_end_cnt;
    run_txn(24'h00_0000, 10'd10, 1'b0);
    repeat (5) @(posedge clk_100m);
    check("s1_act_to_rd", 32'(m_rd - m_act), 32'd3);
    check("s1_bstop", 32'(m_bst - m_rd), 32'd10);
    check("s1_pre", 32'(m_pre - m_rd), 32'd14);
    check("s1_end", 32'(m_end - m_pre), 32'd3);
    check("s1_ack_first", 32'(m_ack_first - m_rd), 32'(3 + OFS));
    check("s1_ack_n", 32'(m_ack_n), 32'd10);
    check("s1_end_pulses", 32'(m_end_cnt - e_before), 32'd1);
    check("s1_nonnop", 32'(m_nonnop), 32'd4);
    for (int k = 0; k < 10 && k < m_data.size(); k++) check("s1_word", 32'(m_data[k]), 32'(k));

    // Column wrap: bank 1, row 5, column 508, len 8
    clear_mon();
    run_txn({2'b01, 13'd5, 9'd508}, 10'd8, 1'b0);
    check("wrap_row", 32'(m_act_addr), 32'd5);
    check("wrap_col", 32'(m_rd_addr), 32'h1FC);
    check("wrap_ack_n", 32'(m_ack_n), 32'd8);
    for (int k = 0; k < 8 && k < m_data.size(); k++) check("wrap_word", 32'(m_data[k]), 32'(exp37[k]));

    // Zero length behaves as one word
    clear_mon();
    run_txn({2'b10, 13'd3, 9'd100}, 10'd0, 1'b0);
    check("len0_ack_n", 32'(m_ack_n), 32'd1);
    check("len0_bstop", 32'(m_bst - m_rd), 32'd1);
    if (m_data.size() > 0) check("len0_word", 32'(m_data[0]), 32'h8664);

    // Reset at t0+5 aborts without PRECHARGE; restart from ACTIVE
    @(posedge clk_100m); #1;
    rd_en = 1'b1; rd_addr = {2'b11, 13'd77, 9'd20}; rd_burst_len = 10'd20;
    pre0 = m_pre_cnt;
    wait_ev(1, m_rd_cnt, "rst_rd_seen");
    for (int i = 0; i < 50 && cyc < m_rd + 5; i++) @(posedge clk_100m);
    #3;
    rstn = 1'b0;
    clear_from(cyc);
    next_free = 0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk_100m);
    @(negedge clk_100m);
    rstn = 1'b1;
    clear_mon();
    wait_ev(0, m_act_cnt, "restart_act");
    #1;
    rd_en = 1'b0;
    check("restart_first", 32'(m_first_cmd), 32'(CMD_ACTIVE));
    check("restart_nopre", 32'(m_pre_cnt), 32'(pre0));
    wait_ev(2, m_end_cnt, "restart_end");

    // Random traffic, including back-to-back requests
    for (int n = 0; n < 40 && cyc < MAXC - 3000; n++) begin
      logic [9:0] ln;
      ln = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 24));
      run_txn(24'($urandom), ln, 1'($urandom_range(0, 1)));
    end

    @(posedge clk_100m); #1;
    rd_en = 1'b0;
    for (int i = 0; i < 3000 && cyc < next_free + 2; i++) @(posedge clk_100m);
    repeat (3) @(posedge clk_100m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
